draw_arbiter: RTL and testbench



---
 rtl/draw_pkg.sv | 13 +
 rtl/draw_arbiter_rr_picker.sv | 27 ++
 rtl/draw_arbiter.sv | 126 ++++++++++++
 tb/tb_draw_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// Shared types and constants for the draw arbiter slice.
package draw_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] GRANT_CLEAR = 2'd3;
    localparam int COORD_W = 9;
    localparam int COLOR_W = 3;

endpackage

// File: rtl/draw_arbiter_rr_picker.sv
// Round-robin winner selection: first valid requester at or after rr_ptr, modulo 3.
module rr_picker (
    input  logic [2:0] req_valid,
    input  logic [1:0] rr_ptr,
    output logic       any_valid,
    output logic [1:0] win_idx
);

    always_comb begin : pick
        int unsigned idx;
        logic [1:0]  idx2;
        any_valid = 1'b0;
        win_idx   = '0;
        idx       = 0;
        idx2      = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= 3) idx = idx - 3;
            idx2 = 2'(idx);
            if (!any_valid && req_valid[idx2]) begin
                any_valid = 1'b1;
                win_idx   = idx2;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Shares one box drawer between three requesters plus a per-frame background clear.
// Optional overrun counter enabled by DRAW_ARBITER_OVERRUN_EN.
module draw_arbiter
    import draw_pkg::*;
#(
    parameter int              NUM_REQ       = 3,
    parameter logic [8:0]      SCREEN_WIDTH  = 9'd320,
    parameter logic [8:0]      SCREEN_HEIGHT = 9'd240,
    parameter logic [2:0]      BG_COLOR      = 3'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        frame_tick,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [26:0] req_x,
    input  logic [26:0] req_y,
    input  logic [26:0] req_w,
    input  logic [26:0] req_h,
    input  logic [8:0]  req_color,
    input  logic        m_ready,
    output logic        m_valid,
    output logic [8:0]  out_box_x,
    output logic [8:0]  out_box_y,
    output logic [8:0]  out_box_w,
    output logic [8:0]  out_box_h,
    output logic [2:0]  out_box_color,
    output logic [1:0]  grant_id
`ifdef DRAW_ARBITER_OVERRUN_EN
    ,
    output logic [15:0] overrun_count
`endif
);

    state_t     state, state_nxt;
    logic [1:0] rr_ptr;
    logic       clear_pending;
    logic       any_valid;
    logic [1:0] win_idx;
    logic       take_clear;
    logic       take_req;

    rr_picker u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .any_valid (any_valid),
        .win_idx   (win_idx)
    );

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        take_clear = 1'b0;
        take_req   = 1'b0;
        case (state)
            S_IDLE: begin
                if (clear_pending) begin
                    take_clear = 1'b1;
                    state_nxt  = S_HOLD;
                end else if (any_valid) begin
                    take_req  = 1'b1;
                    req_ready = 3'b001 << win_idx;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (m_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        if (!reset_n) begin
            req_ready  = '0;
            take_clear = 1'b0;
            take_req   = 1'b0;
        end
    end

    assign m_valid = (state == S_HOLD);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            rr_ptr        <= '0;
            clear_pending <= 1'b0;
            out_box_x     <= '0;
            out_box_y     <= '0;
            out_box_w     <= '0;
            out_box_h     <= '0;
            out_box_color <= '0;
            grant_id      <= '0;
        end else begin
            state <= state_nxt;
            // A tick coinciding with consumption re-arms, so one more clear follows.
            if (take_clear) clear_pending <= frame_tick;
            else            clear_pending <= clear_pending | frame_tick;
            if (take_clear) begin
                out_box_x     <= '0;
                out_box_y     <= '0;
                out_box_w     <= SCREEN_WIDTH;
                out_box_h     <= SCREEN_HEIGHT;
                out_box_color <= BG_COLOR;
                grant_id      <= GRANT_CLEAR;
            end else if (take_req) begin
                out_box_x     <= req_x[COORD_W*win_idx +: COORD_W];
                out_box_y     <= req_y[COORD_W*win_idx +: COORD_W];
                out_box_w     <= req_w[COORD_W*win_idx +: COORD_W];
                out_box_h     <= req_h[COORD_W*win_idx +: COORD_W];
                out_box_color <= req_color[COLOR_W*win_idx +: COLOR_W];
                grant_id      <= win_idx;
                rr_ptr        <= (win_idx == 2'(NUM_REQ - 1)) ? '0 : win_idx + 2'd1;
            end
        end
    end

`ifdef DRAW_ARBITER_OVERRUN_EN
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overrun_count <= '0;
        end else if (frame_tick && overrun_count != 16'hFFFF &&
                     (clear_pending || (state == S_HOLD && grant_id == GRANT_CLEAR))) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed plus randomized bench for draw_arbiter against a transaction-level model.
// Checks overrun_count too when DRAW_ARBITER_OVERRUN_EN is defined.
module tb_draw_arbiter;

    logic        clock;
    logic        reset_n;
    logic        frame_tick;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [26:0] req_x, req_y, req_w, req_h;
    logic [8:0]  req_color;
    logic        m_ready;
    logic        m_valid;
    logic [8:0]  out_box_x, out_box_y, out_box_w, out_box_h;
    logic [2:0]  out_box_color;
    logic [1:0]  grant_id;
`ifdef DRAW_ARBITER_OVERRUN_EN
    logic [15:0] overrun_count;
`endif

    draw_arbiter #(
        .NUM_REQ       (3),
        .SCREEN_WIDTH  (9'd320),
        .SCREEN_HEIGHT (9'd240),
        .BG_COLOR      (3'd0)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .frame_tick    (frame_tick),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_w         (req_w),
        .req_h         (req_h),
        .req_color     (req_color),
        .m_ready       (m_ready),
        .m_valid       (m_valid),
        .out_box_x     (out_box_x),
        .out_box_y     (out_box_y),
        .out_box_w     (out_box_w),
        .out_box_h     (out_box_h),
        .out_box_color (out_box_color),
        .grant_id      (grant_id)
`ifdef DRAW_ARBITER_OVERRUN_EN
        ,
        .overrun_count (overrun_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: one output slot, a pending-clear flag, next-priority requester.
    bit         slot_full;
    logic [8:0] mx, my, mw, mh;
    logic [2:0] mc;
    logic [1:0] mg;
    bit         pend;
    int         next_pri;
    int         ovr;
    logic [2:0] exp_ready;
    bit         auto_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_ready();
        int i;
        if (!reset_n || slot_full || pend) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            i = (next_pri + k) % 3;
            if (req_valid[i]) return 3'(1 << i);
        end
        return 3'b000;
    endfunction

    task automatic set_box(input int i, input logic [8:0] x, input logic [8:0] y,
                           input logic [8:0] w, input logic [8:0] h, input logic [2:0] c);
        req_x[9*i +: 9]     = x;
        req_y[9*i +: 9]     = y;
        req_w[9*i +: 9]     = w;
        req_h[9*i +: 9]     = h;
        req_color[3*i +: 3] = c;
    endtask

    // One clock: check req_ready before the edge, advance the model, check registered outputs.
    task automatic cycle();
        int i;
        #1;
        exp_ready = model_ready();
        check("req_ready", {29'd0, req_ready}, {29'd0, exp_ready});
        @(posedge clock);
        if (!reset_n) begin
            slot_full = 0; pend = 0; next_pri = 0; ovr = 0;
            mx = '0; my = '0; mw = '0; mh = '0; mc = '0; mg = '0;
        end else begin
            if (frame_tick && (pend || (slot_full && mg == 2'd3)) && ovr < 65535) ovr++;
            if (slot_full) begin
                if (m_ready) slot_full = 0;
                pend = pend | frame_tick;
            end else if (pend) begin
                slot_full = 1;
                mx = 9'd0; my = 9'd0; mw = 9'd320; mh = 9'd240; mc = 3'd0; mg = 2'd3;
                pend = frame_tick;
            end else begin
                pend = pend | frame_tick;
                if (exp_ready != 3'b000) begin
                    i = (exp_ready == 3'b001) ? 0 : (exp_ready == 3'b010) ? 1 : 2;
                    slot_full = 1;
                    mx = req_x[9*i +: 9]; my = req_y[9*i +: 9];
                    mw = req_w[9*i +: 9]; mh = req_h[9*i +: 9];
                    mc = req_color[3*i +: 3];
                    mg = 2'(i);
                    next_pri = (i + 1) % 3;
                end
            end
        end
        #1;
        check("m_valid", {31'd0, m_valid}, {31'd0, slot_full});
        check("grant_id", {30'd0, grant_id}, {30'd0, mg});
        check("box_xy", {14'd0, out_box_x, out_box_y}, {14'd0, mx, my});
        check("box_whc", {11'd0, out_box_w, out_box_h, out_box_color}, {11'd0, mw, mh, mc});
`ifdef DRAW_ARBITER_OVERRUN_EN
        check("overrun", {16'd0, overrun_count}, 32'(ovr));
`endif
        @(negedge clock);
        frame_tick = 1'b0;
        if (auto_drop) req_valid = req_valid & ~exp_ready;
    endtask

    task automatic drain();
        req_valid = '0; m_ready = 1'b1; frame_tick = 1'b0;
        repeat (3) cycle();
    endtask

    logic [1:0] grants[$];
    logic [1:0] want_order[4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    int rr_ones;

    initial begin
        slot_full = 0; pend = 0; next_pri = 0; ovr = 0; auto_drop = 0;
        mx = '0; my = '0; mw = '0; mh = '0; mc = '0; mg = '0;
        reset_n = 1'b0; frame_tick = 1'b0; req_valid = '0; m_ready = 1'b1;
        req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_color = '0;
        @(negedge clock);
        repeat (2) cycle();
        reset_n = 1'b1;

        // Frame tick produces one full-screen clear box.
        frame_tick = 1'b1;
        cycle();
        cycle();
        check("clear_w", {23'd0, out_box_w}, 32'd320);
        check("clear_h", {23'd0, out_box_h}, 32'd240);
        check("clear_gid", {30'd0, grant_id}, 32'd3);
        cycle();

        // All three valid and held: grants rotate 0,1,2,0 with single-cycle ready pulses.
        set_box(0, 9'd1, 9'd2, 9'd3, 9'd4, 3'd1);
        set_box(1, 9'd11, 9'd12, 9'd13, 9'd14, 3'd2);
        set_box(2, 9'd21, 9'd22, 9'd23, 9'd24, 3'd3);
        req_valid = 3'b111;
        rr_ones = 0;
        repeat (8) begin
            cycle();
            if (slot_full) grants.push_back(grant_id);
        end
        check("rr_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4 && k < grants.size(); k++)
            check("rr_order", {30'd0, grants[k]}, {30'd0, want_order[k]});
        drain();

        // Requester 1 held by backpressure for five cycles.
        auto_drop = 1;
        set_box(1, 9'd100, 9'd50, 9'd10, 9'd48, 3'd5);
        req_valid = 3'b010; m_ready = 1'b0;
        repeat (6) cycle();
        check("hold_x", {23'd0, out_box_x}, 32'd100);
        check("hold_h", {23'd0, out_box_h}, 32'd48);
        m_ready = 1'b1;
        repeat (3) cycle();

        // Tick in the same cycle requester 0 wins: its box first, then the clear.
        set_box(0, 9'd7, 9'd8, 9'd9, 9'd10, 3'd6);
        req_valid = 3'b001; frame_tick = 1'b1;
        cycle();
        check("tick_first_gid", {30'd0, grant_id}, 32'd0);
        set_box(2, 9'd30, 9'd31, 9'd32, 9'd33, 3'd7);
        req_valid = 3'b100;
        cycle();
        cycle();
        check("tick_then_clear", {30'd0, grant_id}, 32'd3);
        repeat (3) cycle();
        drain();

        // Two ticks while a clear is already pending merge into one clear.
        set_box(0, 9'd5, 9'd5, 9'd5, 9'd5, 3'd1);
        req_valid = 3'b001; m_ready = 1'b0;
        cycle();
        frame_tick = 1'b1; cycle();
        frame_tick = 1'b1; cycle();
        m_ready = 1'b1;
        repeat (6) cycle();
`ifdef DRAW_ARBITER_OVERRUN_EN
        check("overrun_merge", {16'd0, overrun_count}, 32'd1);
`endif
        drain();

        // Reset during hold drops the box and restarts arbitration at requester 0.
        req_valid = 3'b010; m_ready = 1'b0;
        repeat (2) cycle();
        reset_n = 1'b0;
        cycle();
        check("rst_mvalid", {31'd0, m_valid}, 32'd0);
        reset_n = 1'b1; auto_drop = 0;
        req_valid = 3'b111; m_ready = 1'b1;
        cycle();
        check("rst_next_gid", {30'd0, grant_id}, 32'd0);
        drain();

        // Randomized traffic with occasional ticks, backpressure and resets.
        auto_drop = 1;
        repeat (600) begin
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && ($urandom % 3 == 0)) begin
                    set_box(i, 9'($urandom), 9'($urandom), 9'($urandom), 9'($urandom), 3'($urandom));
                    req_valid[i] = 1'b1;
                end
            end
            m_ready    = 1'($urandom % 3 != 0);
            frame_tick = 1'($urandom % 8 == 0);
            reset_n    = 1'($urandom % 150 != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
